// File: rtl/fsm_state_monitor.sv
// fsm_state_monitor
// Consumes the 1-bit state stream of an upstream FSM. Enabled samples are
// deserialised into WORD_W-bit words offered on a valid/ready port. In
// parallel a checker verifies the stream is periodic: one 1 followed by
// PERIOD-1 zeros.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   en         sample enable; bit_in is consumed only when en=1
//   bit_in     sampled stream bit
//   word_valid output word available
//   word_ready consumer accepts when word_valid && word_ready
//   word_data  deserialised word, first sample in bit 0
//   overflow   sticky: a completed word was dropped (held word not taken)
//   lock       checker is LOCKED
//   err_pulse  one-cycle pulse per pattern violation
//   err_count  saturating violation count
//   clr_err    synchronous clear of err_count and overflow
module fsm_state_monitor #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned PERIOD = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              bit_in,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              overflow,
  output logic              lock,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  input  logic              clr_err
);

  localparam int unsigned BitCntW = $clog2(WORD_W);
  localparam int unsigned PhaseW  = $clog2(PERIOD);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  // ---------------------------------------------------------------------------
  // Deserialiser
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [BitCntW-1:0] bitcnt_q, bitcnt_d;
  logic               word_done;
  logic               word_load;
  logic               valid_d;
  logic [WORD_W-1:0]  data_d;
  logic               ovf_d;

  assign word_done = en && (bitcnt_q == BitCntW'(WORD_W - 1));
  // A finished word can be taken if the output slot is empty or being drained.
  assign word_load = word_done && (!word_valid || word_ready);

  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    if (en) begin
      shift_d[bitcnt_q] = bit_in;
      bitcnt_d          = word_done ? '0 : bitcnt_q + BitCntW'(1);
    end
  end

  always_comb begin
    valid_d = word_valid;
    data_d  = word_data;
    ovf_d   = overflow;
    if (word_load) begin
      valid_d = 1'b1;
      data_d  = shift_d;  // includes the sample taken on this edge
    end else if (word_ready) begin
      valid_d = 1'b0;
    end
    if (word_done && !word_load) begin
      ovf_d = 1'b1;
    end
    if (clr_err) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q    <= '0;
      bitcnt_q   <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      overflow   <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      word_valid <= valid_d;
      word_data  <= data_d;
      overflow   <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern checker
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic                mismatch;
  logic                expect_one;
  logic                err_pulse_d;
  logic [CNT_W-1:0]    err_count_d;

  assign expect_one = (phase_q == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StHunt;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    mismatch = 1'b0;
    if (en) begin
      unique case (state_q)
        StHunt: begin
          if (bit_in) begin
            state_d = StVerify;
            phase_d = PhaseW'(1);
          end
        end
        StVerify, StLocked: begin
          if (bit_in == expect_one) begin
            phase_d = (phase_q == PhaseW'(PERIOD - 1)) ? '0 : phase_q + PhaseW'(1);
            if (state_q == StVerify && bit_in) begin
              state_d = StLocked;
            end
          end else begin
            mismatch = 1'b1;
            state_d  = StHunt;
            phase_d  = '0;
          end
        end
        default: begin
          state_d = StHunt;
          phase_d = '0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    lock        = (state_q == StLocked);
    err_pulse_d = mismatch;
    err_count_d = err_count;
    if (clr_err) begin
      err_count_d = '0;
    end else if (mismatch && (err_count != {CNT_W{1'b1}})) begin
      err_count_d = err_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= err_pulse_d;
      err_count <= err_count_d;
    end
  end

endmodule

// File: doc/fsm_state_monitor.md
Name: fsm_state_monitor

Overview:
- Downstream consumer of the 3-state FSM's 1-bit `state_out` stream.
- Deserialises sampled bits into WORD_W-bit words and presents them on a valid/ready interface for a logging or bus-side consumer.
- In parallel, checks that the stream has the expected periodic shape: exactly one 1 every PERIOD samples.
- Reports lock status, per-error pulses and a saturating error count.

Parameters:
- WORD_W, 8: bits per output word; >= 2.
- PERIOD, 3: expected period of the bit pattern in enabled samples (one 1 followed by PERIOD-1 zeros); >= 2.
- CNT_W, 16: width of the error counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  sample enable; bit_in is consumed only on edges where en=1.
- bit_in  input  1  state bit from the upstream FSM (`state_out`).
- word_valid  output  1  output word available.
- word_ready  input  1  consumer accepts the word when word_valid && word_ready.
- word_data  output  WORD_W  deserialised word; the first sampled bit is in bit 0.
- overflow  output  1  sticky: a completed word was dropped because the output register was occupied.
- lock  output  1  checker is in the LOCKED state.
- err_pulse  output  1  one-cycle pulse per detected pattern violation.
- err_count  output  CNT_W  violations since reset or since the last clr_err; saturates at all-ones.
- clr_err  input  1  synchronous clear of err_count and overflow.

Behaviour:
Reset (reset=0, asynchronous):
- All outputs 0.
- Shift register and bit counter 0.
- Checker state HUNT, phase 0.

Deserialiser:
- On each enabled edge, bit_in is written to shift position bitcnt; bitcnt increments.
- When the sample with bitcnt=WORD_W-1 is taken, bitcnt wraps to 0 and the assembled word (including that sample) completes.
- A completed word is loaded into word_data and word_valid is set on the same edge, if either:
  - word_valid=0, or
  - word_valid && word_ready on that edge (back-to-back transfer, no bubble).
  - Latency: word_valid is high the cycle after the WORD_W-th enabled sample.
- Otherwise the word is dropped, overflow is set, word_data is unchanged, and deserialising continues without a stall.
- Handshake: word_valid falls after an edge with word_ready=1, unless a new word loads on that edge. word_data is stable while word_valid && !word_ready.

Checker state machine (evaluated on enabled edges only):
- HUNT:
  - bit_in=1: go to VERIFY, phase<=1.
  - bit_in=0: stay in HUNT. No errors are raised in HUNT.
- VERIFY / LOCKED:
  - Expected bit = 1 when phase==0, else 0.
  - Match: phase<=(phase==PERIOD-1)?0:phase+1. In VERIFY, a matching 1 at phase 0 moves to LOCKED.
  - Mismatch: err_pulse=1 for the next cycle, err_count+1 (saturating), state<=HUNT, phase<=0.
- lock = (state==LOCKED); lock is registered.

Simultaneous events:
- clr_err on the same edge as an error: err_count<=0, but err_pulse still asserts.
- clr_err on the same edge as a drop: overflow<=0.
- en=0: all checker and deserialiser state is frozen. The output handshake continues.

Mid-operation reset:
- Clears any partial word and any held word.
- Re-entry starts at bitcnt 0 in HUNT.

Test Plan:
1. Alignment and word value: reset, en=1, word_ready=1; feed 0,1,0,0,1,0,0,1.
   - Required: word_valid=1 for exactly one cycle, the cycle after sample 8, with word_data=0x92.
   - lock=0 through sample 4; lock=1 from the cycle after sample 5 (the second 1).
2. Continuous stream: feed 24 samples of the repeating 0,1,0 pattern with word_ready=1.
   - Required: three words 0x92, 0x24, 0x49; lock stays 1 once set; err_count=0.
3. Pattern violation: lock, then feed 1,1.
   - Required: err_pulse high for one cycle; err_count=1; lock=0.
   - A subsequent 1,0,0,1 relocks.
   - 0,0,0 while locked also gives err_count+1.
4. Backpressure: word_ready=0, feed 16 samples of the 0,1,0 pattern.
   - Required: word_data holds 0x92 with word_valid=1.
   - The second word is dropped and overflow=1.
   - Then word_ready=1 for one cycle: word_valid=0, and overflow stays 1 until clr_err.
5. Enable gaps and saturation:
   - Insert en=0 cycles between samples of case 1 (bit_in toggled randomly while en=0). Required: identical results to case 1.
   - With CNT_W=2, inject 5 violations. Required: err_count=3.
6. Mid-word reset: assert reset=0 after sample 5 of case 1, release, and feed case 1 again.
   - Required: all outputs 0 during reset; the next word is 0x92 and no stale bits appear.
